ppb_panel_ctrl: RTL and testbench
=================================

PPB_PANEL_CTRL -- requirements
Module: ppb_panel_ctrl

Interface
REQ-001 The block SHALL provide parameter N_IN, default 60, meaning width of device_inputs.
REQ-002 The block SHALL provide parameter N_OUT, default 120, meaning width of device_outputs.
REQ-003 The block SHALL provide parameter DATA_W, default 8, meaning monitored/injected bus width.
REQ-004 The block SHALL provide parameter N_MON, default 4, meaning number of monitored buses (N_MON*DATA_W <= N_OUT).
REQ-005 The block SHALL provide parameter DEB_CYCLES, default 16, meaning debounce stability count (>= 2).
REQ-006 clk  input  1  sole clock, all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 device_inputs  input  N_IN  raw panel switches/buttons, asynchronous to clk.
REQ-009 mon_bus  input  N_MON*DATA_W  buses to display; bus k at [k*DATA_W +: DATA_W].
REQ-010 device_outputs  output  N_OUT  panel LEDs.
REQ-011 clk_auto_en  output  1  free-running CPU clock enable.
REQ-012 clk_step  output  1  single-cycle CPU step pulse.
REQ-013 cpu_reset  output  1  CPU reset request.
REQ-014 mux_select  output  2  bus multiplexer select.
REQ-015 ar_load  output  1  single-cycle address-register load pulse.
REQ-016 inj_data  output  DATA_W  data-bus injection value.
REQ-017 inj_valid / inj_ready  output / input  1 / 1  injection handshake.

Function
REQ-018 Input bit map SHALL be: 0 auto-clock, 1 step, 2 reset, 3-4 mux_select (bit 3 = MSB), 5..5+DATA_W-1 inject data (bit 5 = MSB), 13 AR load, 14 inject request.
REQ-019 Every used input SHALL pass a 2-flop synchroniser, then a debouncer; debounced value changes only after the synchronised value differs from it for DEB_CYCLES consecutive cycles; any bounce restarts the count.
REQ-020 clk_auto_en, mux_select, inj_data SHALL be the debounced levels.
REQ-021 clk_step SHALL pulse exactly one cycle on each debounced rising edge of bit 1, suppressed while clk_auto_en=1.
REQ-022 ar_load SHALL pulse exactly one cycle on each debounced rising edge of bit 13.
REQ-023 cpu_reset SHALL equal debounced bit 2 OR reset.
REQ-024 Injection FSM states: IDLE, HOLD, WAIT_REL. IDLE->HOLD on debounced rising edge of bit 14; HOLD asserts inj_valid, inj_data frozen at entry value; HOLD->WAIT_REL on cycle with inj_valid&&inj_ready; WAIT_REL->IDLE when debounced bit 14 = 0.
REQ-025 inj_valid SHALL not drop before inj_ready is sampled high; a release of bit 14 during HOLD SHALL not abort the transfer.
REQ-026 device_outputs[k*DATA_W +: DATA_W] SHALL be mon_bus bus k registered one cycle; bits above N_MON*DATA_W SHALL be 0.
REQ-027 Latency raw input to debounced level SHALL be 2+DEB_CYCLES cycles; pulse outputs one cycle after.

Reset
REQ-028 While reset=1: all synchroniser/debounce state 0, counters 0, FSM IDLE, clk_auto_en=0, clk_step=0, ar_load=0, mux_select=0, inj_data=0, inj_valid=0, device_outputs=0, cpu_reset=1.
REQ-029 Reset asserted mid-HOLD SHALL drop inj_valid next cycle; no pulse SHALL be generated from inputs already high at reset release.

Configuration
REQ-030 Macro PPB_DEBOUNCE_EN defined: debouncers per REQ-019; undefined: debouncers bypassed, debounced level = synchroniser output, latency 2 cycles.

Structure
REQ-031 Package ppb_pkg SHALL hold input bit-index constants and the injection-FSM state enum.
REQ-032 Sub-module ppb_debounce (1 bit, DEB_CYCLES parameter) SHALL be instantiated per used input.

Verification
REQ-033 Bit 1 bounces 0/1 every 3 cycles for 30 cycles then held 1, bit 0=0 -> exactly one clk_step pulse, 2+16+1 cycles after stable 1.
REQ-034 Bit 0=1, bit 1 toggled -> clk_step never asserted.
REQ-035 Inject bits = 0xA5, bit 14 raised, inj_ready low 10 cycles then high 1 cycle -> inj_valid held 10+ cycles, inj_data=0xA5 throughout, one transfer; second transfer only after bit 14 released and re-raised.
REQ-036 mon_bus bus 2 = 0x3C -> device_outputs[16:23]=0x3C one cycle later, bits 32..119 = 0.
REQ-037 reset pulsed during HOLD -> inj_valid=0, cpu_reset=1 next cycle; bit 14 held high through release -> no new inj_valid.
REQ-038 Build without PPB_DEBOUNCE_EN, bit 13 rising -> ar_load pulse 3 cycles later, one cycle wide.

Source files
------------

// File: rtl/ppb_pkg.sv
// Shared definitions for the front-panel controller: panel input bit map
// and the injection handshake state encoding.
package ppb_pkg;

  localparam int IDX_AUTO     = 0;
  localparam int IDX_STEP     = 1;
  localparam int IDX_RESET    = 2;
  localparam int IDX_MUX_MSB  = 3;
  localparam int IDX_MUX_LSB  = 4;
  localparam int IDX_DATA_MSB = 5;
  localparam int IDX_AR_LOAD  = 13;
  localparam int IDX_INJ_REQ  = 14;
  localparam int N_USED       = 15;

  typedef enum logic [1:0] {
    INJ_IDLE     = 2'd0,
    INJ_HOLD     = 2'd1,
    INJ_WAIT_REL = 2'd2
  } inj_state_e;

endpackage

// File: rtl/ppb_debounce.sv
// One panel input: 2-flop synchroniser followed by a stability debouncer.
// With PPB_DEBOUNCE_EN undefined the debounced level is the synchroniser output.
module ppb_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync_out,
  output logic deb_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q;

`ifdef PPB_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEB_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             deb_q, deb_d;

  // The count only advances while the input disagrees; any agreement restarts it.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync_q != deb_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        deb_d = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      deb_q <= deb_d;
    end
  end

  assign deb_out = deb_q;
`else
  assign deb_out = sync_q;
`endif

endmodule

// File: rtl/ppb_panel_ctrl.sv
// Front-panel controller: conditions panel switches, generates CPU clock/step,
// reset, AR-load and bus-injection controls, and drives the monitor LEDs.
// Debouncing is enabled by defining PPB_DEBOUNCE_EN.
module ppb_panel_ctrl
  import ppb_pkg::*;
#(
  parameter int N_IN       = 60,
  parameter int N_OUT      = 120,
  parameter int DATA_W     = 8,
  parameter int N_MON      = 4,
  parameter int DEB_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_IN-1:0]         device_inputs,
  input  logic [N_MON*DATA_W-1:0] mon_bus,
  output logic [N_OUT-1:0]        device_outputs,
  output logic                    clk_auto_en,
  output logic                    clk_step,
  output logic                    cpu_reset,
  output logic [1:0]              mux_select,
  output logic                    ar_load,
  output logic [DATA_W-1:0]       inj_data,
  output logic                    inj_valid,
  input  logic                    inj_ready
);

  localparam int USED_W = (IDX_DATA_MSB + DATA_W > N_USED) ? IDX_DATA_MSB + DATA_W : N_USED;

  logic [USED_W-1:0] sync;
  logic [USED_W-1:0] deb;
  logic [DATA_W-1:0] data_lvl;

  genvar gi;
  generate
    for (gi = 0; gi < USED_W; gi++) begin : g_in
      ppb_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk      (clk),
        .reset    (reset),
        .din      (device_inputs[gi]),
        .sync_out (sync[gi]),
        .deb_out  (deb[gi])
      );
    end
    for (gi = 0; gi < DATA_W; gi++) begin : g_data
      assign data_lvl[DATA_W-1-gi] = deb[IDX_DATA_MSB+gi];
    end
    if (N_IN > USED_W) begin : g_spare
      logic unused_spare;
      assign unused_spare = ^device_inputs[N_IN-1:USED_W];
    end
  endgenerate

  logic unused_sync;
  assign unused_sync = ^sync;

  // Edge-detected inputs packed as {inject request, AR load, step}.
  logic [2:0] edge_lvl, edge_sync, rise;
  logic [2:0] prev_q, prev_d;
  logic [2:0] arm_q, arm_d;
  logic [1:0] settle_q, settle_d;
  logic       step_q, step_d;
  logic       ar_q, ar_d;
  inj_state_e state_q, state_d;
  logic [DATA_W-1:0] frozen_q, frozen_d;
  logic [N_OUT-1:0]  out_q, out_d;

  assign edge_lvl  = {deb[IDX_INJ_REQ], deb[IDX_AR_LOAD], deb[IDX_STEP]};
  assign edge_sync = {sync[IDX_INJ_REQ], sync[IDX_AR_LOAD], sync[IDX_STEP]};
  assign rise      = edge_lvl & ~prev_q & arm_q;

  // An edge input is armed only once it has been seen low after the
  // synchroniser refilled, so a switch held through reset never fires.
  always_comb begin
    settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
    arm_d    = arm_q | ({3{settle_q == 2'd2}} & ~edge_sync);
    prev_d   = edge_lvl;
    step_d   = rise[0] & ~deb[IDX_AUTO];
    ar_d     = rise[1];
    out_d    = N_OUT'(mon_bus);
  end

  always_comb begin
    state_d  = state_q;
    frozen_d = frozen_q;
    case (state_q)
      INJ_IDLE: begin
        if (rise[2]) begin
          state_d  = INJ_HOLD;
          frozen_d = data_lvl;
        end
      end
      INJ_HOLD: begin
        if (inj_ready) state_d = INJ_WAIT_REL;
      end
      INJ_WAIT_REL: begin
        if (!deb[IDX_INJ_REQ]) state_d = INJ_IDLE;
      end
      default: state_d = INJ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      settle_q <= '0;
      arm_q    <= '0;
      prev_q   <= '0;
      step_q   <= 1'b0;
      ar_q     <= 1'b0;
      state_q  <= INJ_IDLE;
      frozen_q <= '0;
      out_q    <= '0;
    end else begin
      settle_q <= settle_d;
      arm_q    <= arm_d;
      prev_q   <= prev_d;
      step_q   <= step_d;
      ar_q     <= ar_d;
      state_q  <= state_d;
      frozen_q <= frozen_d;
      out_q    <= out_d;
    end
  end

  assign device_outputs = out_q;
  assign clk_auto_en    = deb[IDX_AUTO];
  assign clk_step       = step_q;
  assign ar_load        = ar_q;
  assign cpu_reset      = deb[IDX_RESET] | reset;
  assign mux_select     = {deb[IDX_MUX_MSB], deb[IDX_MUX_LSB]};
  assign inj_valid      = (state_q == INJ_HOLD);
  assign inj_data       = (state_q == INJ_HOLD) ? frozen_q : data_lvl;

endmodule

// File: tb/tb_ppb_panel_ctrl.sv
// Directed self-checking bench for ppb_panel_ctrl; expected latencies follow
// whether PPB_DEBOUNCE_EN is defined for the build.
module tb_ppb_panel_ctrl;

`ifdef PPB_DEBOUNCE_EN
  localparam int LAT    = 2 + 16;
  localparam int DEB_ON = 1;
`else
  localparam int LAT    = 2;
  localparam int DEB_ON = 0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [59:0]  device_inputs;
  logic [31:0]  mon_bus;
  logic [119:0] device_outputs;
  logic         clk_auto_en, clk_step, cpu_reset, ar_load, inj_valid, inj_ready;
  logic [1:0]   mux_select;
  logic [7:0]   inj_data;

  int pass_cnt  = 0;
  int total_cnt = 0;

  ppb_panel_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .device_inputs  (device_inputs),
    .mon_bus        (mon_bus),
    .device_outputs (device_outputs),
    .clk_auto_en    (clk_auto_en),
    .clk_step       (clk_step),
    .cpu_reset      (cpu_reset),
    .mux_select     (mux_select),
    .ar_load        (ar_load),
    .inj_data       (inj_data),
    .inj_valid      (inj_valid),
    .inj_ready      (inj_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_data(input logic [7:0] v);
    for (int j = 0; j < 8; j++) device_inputs[5+j] = v[7-j];
  endtask

  task automatic test_reset();
    reset = 1'b1; device_inputs = '0; mon_bus = 32'hDEADBEEF; inj_ready = 1'b0;
    wait_ticks(3);
    total_cnt++; if (clk_auto_en !== 1'b0) $display("FAIL rst_auto got=%b want=0", clk_auto_en); else pass_cnt++;
    total_cnt++; if (clk_step !== 1'b0) $display("FAIL rst_step got=%b want=0", clk_step); else pass_cnt++;
    total_cnt++; if (ar_load !== 1'b0) $display("FAIL rst_ar got=%b want=0", ar_load); else pass_cnt++;
    total_cnt++; if (mux_select !== 2'd0) $display("FAIL rst_mux got=%0d want=0", mux_select); else pass_cnt++;
    total_cnt++; if (inj_data !== 8'h00) $display("FAIL rst_data got=%h want=00", inj_data); else pass_cnt++;
    total_cnt++; if (inj_valid !== 1'b0) $display("FAIL rst_valid got=%b want=0", inj_valid); else pass_cnt++;
    total_cnt++; if (device_outputs !== 120'd0) $display("FAIL rst_leds got=%h want=0", device_outputs); else pass_cnt++;
    total_cnt++; if (cpu_reset !== 1'b1) $display("FAIL rst_cpu_reset got=%b want=1", cpu_reset); else pass_cnt++;
    reset = 1'b0; mon_bus = '0;
    wait_ticks(4);
    total_cnt++; if (cpu_reset !== 1'b0) $display("FAIL rel_cpu_reset got=%b want=0", cpu_reset); else pass_cnt++;
    $display("test_reset done");
  endtask

  task automatic test_levels();
    logic [1:0] exp_mux;
    logic       exp_cr;
    device_inputs[3] = 1'b1; device_inputs[2] = 1'b1;
    for (int t = 1; t <= LAT + 1; t++) begin
      tick();
      exp_mux = (t >= LAT) ? 2'd2 : 2'd0;
      exp_cr  = (t >= LAT);
      total_cnt++; if (mux_select !== exp_mux) $display("FAIL mux_lat t=%0d got=%0d want=%0d", t, mux_select, exp_mux); else pass_cnt++;
      total_cnt++; if (cpu_reset !== exp_cr) $display("FAIL cpurst_lat t=%0d got=%b want=%b", t, cpu_reset, exp_cr); else pass_cnt++;
    end
    device_inputs[3] = 1'b0; device_inputs[2] = 1'b0; device_inputs[4] = 1'b1;
    wait_ticks(LAT + 1);
    total_cnt++; if (mux_select !== 2'd1) $display("FAIL mux_lsb got=%0d want=1", mux_select); else pass_cnt++;
    total_cnt++; if (cpu_reset !== 1'b0) $display("FAIL cpurst_off got=%b want=0", cpu_reset); else pass_cnt++;
    device_inputs[4] = 1'b0;
    wait_ticks(LAT + 1);
    total_cnt++; if (mux_select !== 2'd0) $display("FAIL mux_clear got=%0d want=0", mux_select); else pass_cnt++;
    $display("test_levels done");
  endtask

  task automatic test_step_bounce();
    int n_pulse, last_t, t, exp_n;
    n_pulse = 0; last_t = -1; t = 0;
    for (int i = 0; i < 10; i++) begin
      device_inputs[1] = i[0];
      for (int c = 0; c < 3; c++) begin
        tick(); t++;
        if (clk_step === 1'b1) begin n_pulse++; last_t = t; end
      end
    end
    for (int c = 0; c < LAT + 6; c++) begin
      tick(); t++;
      if (clk_step === 1'b1) begin n_pulse++; last_t = t; end
    end
    exp_n = (DEB_ON != 0) ? 1 : 5;
    total_cnt++; if (n_pulse !== exp_n) $display("FAIL step_count got=%0d want=%0d", n_pulse, exp_n); else pass_cnt++;
    total_cnt++; if (last_t !== 27 + LAT + 1) $display("FAIL step_time got=%0d want=%0d", last_t, 27 + LAT + 1); else pass_cnt++;
    device_inputs[1] = 1'b0;
    wait_ticks(LAT + 3);
    $display("test_step_bounce pulses=%0d last=%0d", n_pulse, last_t);
  endtask

  task automatic test_auto_suppress();
    int n_pulse;
    n_pulse = 0;
    device_inputs[0] = 1'b1;
    wait_ticks(LAT + 1);
    total_cnt++; if (clk_auto_en !== 1'b1) $display("FAIL auto_on got=%b want=1", clk_auto_en); else pass_cnt++;
    for (int k = 0; k < 2; k++) begin
      device_inputs[1] = 1'b1;
      for (int c = 0; c < LAT + 4; c++) begin tick(); if (clk_step === 1'b1) n_pulse++; end
      device_inputs[1] = 1'b0;
      for (int c = 0; c < LAT + 4; c++) begin tick(); if (clk_step === 1'b1) n_pulse++; end
    end
    total_cnt++; if (n_pulse !== 0) $display("FAIL auto_suppress got=%0d pulses want=0", n_pulse); else pass_cnt++;
    device_inputs[0] = 1'b0;
    wait_ticks(LAT + 2);
    total_cnt++; if (clk_auto_en !== 1'b0) $display("FAIL auto_off got=%b want=0", clk_auto_en); else pass_cnt++;
    $display("test_auto_suppress done");
  endtask

  task automatic test_ar_load();
    logic exp_ar;
    device_inputs[13] = 1'b1;
    for (int t = 1; t <= LAT + 3; t++) begin
      tick();
      exp_ar = (t == LAT + 1);
      total_cnt++; if (ar_load !== exp_ar) $display("FAIL ar_load t=%0d got=%b want=%b", t, ar_load, exp_ar); else pass_cnt++;
    end
    device_inputs[13] = 1'b0;
    wait_ticks(LAT + 3);
    $display("test_ar_load done");
  endtask

  task automatic test_inject();
    logic exp_v;
    int   n_valid;
    set_data(8'hA5);
    wait_ticks(LAT + 1);
    total_cnt++; if (inj_data !== 8'hA5) $display("FAIL inj_level got=%h want=a5", inj_data); else pass_cnt++;
    device_inputs[14] = 1'b1; inj_ready = 1'b0;
    for (int t = 1; t <= LAT + 1; t++) begin
      tick();
      exp_v = (t == LAT + 1);
      total_cnt++; if (inj_valid !== exp_v) $display("FAIL inj_start t=%0d got=%b want=%b", t, inj_valid, exp_v); else pass_cnt++;
    end
    set_data(8'h00);
    for (int k = 0; k < 10; k++) begin
      tick();
      total_cnt++; if (inj_valid !== 1'b1) $display("FAIL inj_hold k=%0d got=%b want=1", k, inj_valid); else pass_cnt++;
      total_cnt++; if (inj_data !== 8'hA5) $display("FAIL inj_frozen k=%0d got=%h want=a5", k, inj_data); else pass_cnt++;
    end
    inj_ready = 1'b1;
    $display("inject transfer data=%h valid=%b", inj_data, inj_valid);
    tick();
    inj_ready = 1'b0;
    total_cnt++; if (inj_valid !== 1'b0) $display("FAIL inj_done got=%b want=0", inj_valid); else pass_cnt++;
    n_valid = 0;
    for (int c = 0; c < LAT + 5; c++) begin tick(); if (inj_valid === 1'b1) n_valid++; end
    total_cnt++; if (n_valid !== 0) $display("FAIL inj_no_retrig got=%0d want=0", n_valid); else pass_cnt++;
    total_cnt++; if (inj_data !== 8'h00) $display("FAIL inj_unfrozen got=%h want=00", inj_data); else pass_cnt++;
    device_inputs[14] = 1'b0; set_data(8'h5A);
    wait_ticks(LAT + 3);
    device_inputs[14] = 1'b1;
    wait_ticks(LAT + 1);
    total_cnt++; if (inj_valid !== 1'b1) $display("FAIL inj2_valid got=%b want=1", inj_valid); else pass_cnt++;
    total_cnt++; if (inj_data !== 8'h5A) $display("FAIL inj2_data got=%h want=5a", inj_data); else pass_cnt++;
    inj_ready = 1'b1;
    $display("inject transfer data=%h valid=%b", inj_data, inj_valid);
    tick();
    inj_ready = 1'b0;
    total_cnt++; if (inj_valid !== 1'b0) $display("FAIL inj2_done got=%b want=0", inj_valid); else pass_cnt++;
    device_inputs[14] = 1'b0; set_data(8'h00);
    wait_ticks(LAT + 3);
  endtask

  task automatic test_mon_bus();
    mon_bus = {8'h44, 8'h3C, 8'h22, 8'h11};
    total_cnt++; if (device_outputs !== 120'd0) $display("FAIL mon_early got=%h want=0", device_outputs); else pass_cnt++;
    tick();
    total_cnt++; if (device_outputs[23:16] !== 8'h3C) $display("FAIL mon_bus2 got=%h want=3c", device_outputs[23:16]); else pass_cnt++;
    total_cnt++; if (device_outputs[31:24] !== 8'h44) $display("FAIL mon_bus3 got=%h want=44", device_outputs[31:24]); else pass_cnt++;
    total_cnt++; if (device_outputs[15:0] !== 16'h2211) $display("FAIL mon_bus01 got=%h want=2211", device_outputs[15:0]); else pass_cnt++;
    total_cnt++; if (device_outputs[119:32] !== 88'd0) $display("FAIL mon_upper got=%h want=0", device_outputs[119:32]); else pass_cnt++;
    mon_bus[23:16] = 8'hC3;
    tick();
    total_cnt++; if (device_outputs[23:16] !== 8'hC3) $display("FAIL mon_update got=%h want=c3", device_outputs[23:16]); else pass_cnt++;
    mon_bus = '0;
    tick();
    $display("test_mon_bus done");
  endtask

  task automatic test_reset_hold();
    int n_bad;
    set_data(8'h77);
    device_inputs[14] = 1'b1;
    wait_ticks(LAT + 1);
    total_cnt++; if (inj_valid !== 1'b1) $display("FAIL rh_hold got=%b want=1", inj_valid); else pass_cnt++;
    reset = 1'b1;
    tick();
    total_cnt++; if (inj_valid !== 1'b0) $display("FAIL rh_valid got=%b want=0", inj_valid); else pass_cnt++;
    total_cnt++; if (cpu_reset !== 1'b1) $display("FAIL rh_cpu_reset got=%b want=1", cpu_reset); else pass_cnt++;
    reset = 1'b0;
    n_bad = 0;
    for (int c = 0; c < LAT + 10; c++) begin tick(); if (inj_valid === 1'b1) n_bad++; end
    total_cnt++; if (n_bad !== 0) $display("FAIL rh_no_restart got=%0d want=0", n_bad); else pass_cnt++;
    device_inputs[14] = 1'b0;
    wait_ticks(LAT + 3);
    device_inputs[14] = 1'b1;
    wait_ticks(LAT + 1);
    total_cnt++; if (inj_valid !== 1'b1) $display("FAIL rh_rearm got=%b want=1", inj_valid); else pass_cnt++;
    total_cnt++; if (inj_data !== 8'h77) $display("FAIL rh_data got=%h want=77", inj_data); else pass_cnt++;
    inj_ready = 1'b1;
    $display("inject transfer data=%h valid=%b", inj_data, inj_valid);
    tick();
    inj_ready = 1'b0;
    device_inputs[14] = 1'b0;
    wait_ticks(LAT + 3);
  endtask

  initial begin
    test_reset();
    test_levels();
    test_step_bounce();
    test_auto_suppress();
    test_ar_load();
    test_inject();
    test_mon_bus();
    test_reset_hold();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
